// File: rtl/vend_fsm.sv
// Coin vending controller: two coin inputs, parametrised price, vend and change pulses.
// Optional cancel/refund path built when VEND_REFUND_EN is defined.
module vend_fsm #(
  parameter int PRICE    = 2,
  parameter int VAL_A    = 1,
  parameter int VAL_B    = 2,
  parameter int CREDIT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a,
  input  logic                b,
  input  logic                cancel,
  output logic                outp,
  output logic                charge,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCUM  = 3'd1,
    VEND   = 3'd2,
    CHANGE = 3'd3,
    REFUND = 3'd4
  } state_t;

  localparam logic [CREDIT_W:0] P  = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W:0] VA = (CREDIT_W+1)'(VAL_A);
  localparam logic [CREDIT_W:0] VB = (CREDIT_W+1)'(VAL_B);

  state_t              state, state_nx;
  logic [CREDIT_W-1:0] cred, cred_nx;
  logic [CREDIT_W:0]   sum;

`ifndef VEND_REFUND_EN
  logic unused_cancel;
  assign unused_cancel = cancel;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cred  <= '0;
    end else begin
      state <= state_nx;
      cred  <= cred_nx;
    end
  end

  // One extra bit keeps the coin sum exact before the price compare
  assign sum = {1'b0, cred} + (a ? VA : '0) + (b ? VB : '0);

  always_comb begin
    state_nx = state;
    cred_nx  = cred;
    unique case (state)
      IDLE, ACCUM: begin
        if (sum >= P) begin
          state_nx = VEND;
          cred_nx  = CREDIT_W'(sum - P);
        end else if (sum != '0) begin
          state_nx = ACCUM;
          cred_nx  = CREDIT_W'(sum);
`ifdef VEND_REFUND_EN
          if (state == ACCUM && cancel)
            state_nx = REFUND;
`endif
        end else begin
          state_nx = IDLE;
        end
      end
      VEND: begin
        state_nx = (cred != '0) ? CHANGE : IDLE;
      end
`ifdef VEND_REFUND_EN
      CHANGE, REFUND: begin
`else
      CHANGE: begin
`endif
        if (cred <= CREDIT_W'(1)) begin
          state_nx = IDLE;
          cred_nx  = '0;
        end else begin
          cred_nx = cred - CREDIT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cred_nx  = '0;
      end
    endcase
  end

  always_comb begin
    outp   = 1'b0;
    charge = 1'b0;
    busy   = 1'b0;
    unique case (state)
      VEND: begin
        outp = 1'b1;
        busy = 1'b1;
      end
`ifdef VEND_REFUND_EN
      CHANGE, REFUND: begin
`else
      CHANGE: begin
`endif
        charge = 1'b1;
        busy   = 1'b1;
      end
      default: ;
    endcase
  end

  assign credit = cred;

endmodule

// File: tb/tb_vend_fsm.sv
// Directed bench for vend_fsm: three instances with different price/coin values.
// Refund expectations follow VEND_REFUND_EN.
module tb_vend_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0;
  logic b = 1'b0;
  logic cancel = 1'b0;

  logic       o1, c1, y1;
  logic [3:0] k1;
  logic       o4, c4, y4;
  logic [3:0] k4;
  logic       o5, c5, y5;
  logic [3:0] k5;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vend_fsm #(.PRICE(2), .VAL_A(1), .VAL_B(2), .CREDIT_W(4)) u1 (
    .clk(clk), .rst(rst), .a(a), .b(b), .cancel(cancel),
    .outp(o1), .charge(c1), .busy(y1), .credit(k1)
  );

  vend_fsm #(.PRICE(4), .VAL_A(1), .VAL_B(2), .CREDIT_W(4)) u4 (
    .clk(clk), .rst(rst), .a(a), .b(b), .cancel(cancel),
    .outp(o4), .charge(c4), .busy(y4), .credit(k4)
  );

  vend_fsm #(.PRICE(2), .VAL_A(1), .VAL_B(5), .CREDIT_W(4)) u5 (
    .clk(clk), .rst(rst), .a(a), .b(b), .cancel(cancel),
    .outp(o5), .charge(c5), .busy(y5), .credit(k5)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply inputs for one edge, then clear them; sample 1 time unit later
  task automatic tick(input logic ta, input logic tb_, input logic tc);
    a = ta;
    b = tb_;
    cancel = tc;
    @(posedge clk);
    #1;
    a = 1'b0;
    b = 1'b0;
    cancel = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(0, 0, 0);
    rst = 1'b1;
  endtask

  initial begin
    #2;
    do_reset();
    chk("rst_credit", 32'(k1), 0);
    chk("rst_outp", 32'(o1), 0);
    chk("rst_charge", 32'(c1), 0);
    chk("rst_busy", 32'(y1), 0);
    chk("rst_busy_u5", 32'(y5), 0);

    // exact price with two small coins, gap between them
    tick(1, 0, 0);
    chk("t1_credit1", 32'(k1), 1);
    chk("t1_busy0", 32'(y1), 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("t1_hold", 32'(k1), 1);
    tick(1, 0, 0);
    chk("t1_outp", 32'(o1), 1);
    chk("t1_vend_credit", 32'(k1), 0);
    chk("t1_vend_charge", 32'(c1), 0);
    chk("t1_vend_busy", 32'(y1), 1);
    tick(0, 0, 0);
    chk("t1_end_outp", 32'(o1), 0);
    chk("t1_end_charge", 32'(c1), 0);
    chk("t1_end_busy", 32'(y1), 0);

    // overpay by one unit
    do_reset();
    tick(1, 0, 0);
    chk("t2_credit1", 32'(k1), 1);
    tick(0, 1, 0);
    chk("t2_outp", 32'(o1), 1);
    chk("t2_vend_charge", 32'(c1), 0);
    chk("t2_vend_credit", 32'(k1), 1);
    tick(0, 0, 0);
    chk("t2_charge", 32'(c1), 1);
    chk("t2_chg_outp", 32'(o1), 0);
    chk("t2_chg_busy", 32'(y1), 1);
    tick(0, 0, 0);
    chk("t2_end_charge", 32'(c1), 0);
    chk("t2_end_busy", 32'(y1), 0);
    chk("t2_end_credit", 32'(k1), 0);

    // PRICE=4: simultaneous coins, then b; coins while busy are dropped
    do_reset();
    tick(1, 1, 0);
    chk("t3_credit3", 32'(k4), 3);
    chk("t3_outp0", 32'(o4), 0);
    tick(0, 1, 0);
    chk("t3_outp", 32'(o4), 1);
    chk("t3_vend_credit", 32'(k4), 1);
    tick(0, 1, 0);
    chk("t4_chg_credit", 32'(k4), 1);
    chk("t4_chg_charge", 32'(c4), 1);
    chk("t4_chg_outp", 32'(o4), 0);
    tick(0, 1, 0);
    chk("t4_end_credit", 32'(k4), 0);
    chk("t4_end_outp", 32'(o4), 0);
    chk("t4_end_busy", 32'(y4), 0);
    tick(0, 0, 0);
    chk("t4_quiet_outp", 32'(o4), 0);

    // cancel from ACCUM
    do_reset();
    tick(0, 1, 0);
    chk("t5_credit2", 32'(k4), 2);
    tick(0, 0, 1);
`ifdef VEND_REFUND_EN
    chk("t5_ref1_charge", 32'(c4), 1);
    chk("t5_ref1_outp", 32'(o4), 0);
    chk("t5_ref1_credit", 32'(k4), 2);
    tick(0, 0, 0);
    chk("t5_ref2_charge", 32'(c4), 1);
    chk("t5_ref2_credit", 32'(k4), 1);
    tick(0, 0, 0);
    chk("t5_end_charge", 32'(c4), 0);
    chk("t5_end_busy", 32'(y4), 0);
    chk("t5_end_credit", 32'(k4), 0);
    tick(0, 0, 1);
    chk("t5_idle_cancel", 32'(y4), 0);
`else
    chk("t5_nc_credit", 32'(k4), 2);
    chk("t5_nc_charge", 32'(c4), 0);
    chk("t5_nc_busy", 32'(y4), 0);
    tick(0, 0, 0);
    chk("t5_nc_hold", 32'(k4), 2);
`endif

    // VAL_B=5: reset in the middle of change
    do_reset();
    tick(0, 1, 0);
    chk("t6_outp", 32'(o5), 1);
    chk("t6_vend_credit", 32'(k5), 3);
    tick(0, 0, 0);
    chk("t6_chg1", 32'(c5), 1);
    chk("t6_chg1_credit", 32'(k5), 3);
    tick(0, 0, 0);
    chk("t6_chg2", 32'(c5), 1);
    chk("t6_chg2_credit", 32'(k5), 2);
    rst = 1'b0;
    tick(0, 0, 0);
    chk("t6_rst_charge", 32'(c5), 0);
    chk("t6_rst_outp", 32'(o5), 0);
    chk("t6_rst_busy", 32'(y5), 0);
    chk("t6_rst_credit", 32'(k5), 0);
    rst = 1'b1;
    tick(0, 0, 0);
    chk("t6_after_credit", 32'(k5), 0);
    chk("t6_after_charge", 32'(c5), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vend_fsm.md
# vend_fsm

Parametrised coin-operated vending controller. It accumulates credit from two coin inputs against a configurable price and issues a one-cycle vend pulse. Any excess is returned as one change pulse per credit unit, and a cancel/refund path can be compiled in. It is the next-generation replacement for the fixed two-coin/fixed-price drink controller and sits between the coin-acceptor front end and the dispenser/change-hopper drivers.

## Interface
- `PRICE`, 2: item price in credit units (1 unit = value of a small coin). Legal range ≥ 2.
- `VAL_A`, 1: units credited by coin input `a`. Must be ≥ 1.
- `VAL_B`, 2: units credited by coin input `b`. Must be ≥ 1.
- `CREDIT_W`, 4: credit register width. Must hold `PRICE-1+VAL_A+VAL_B`.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-low. Sampled on the `clk` rising edge.
- `a` in 1: coin A present, one cycle per coin.
- `b` in 1: coin B present, one cycle per coin.
- `cancel` in 1: refund request. Level sampled each cycle.
- `outp` out 1: vend pulse, exactly one cycle per item.
- `charge` out 1: change pulse; each high cycle returns one unit.
- `busy` out 1: high in VEND/CHANGE/REFUND. Coins are rejected while busy.
- `credit` out `CREDIT_W`: current credit in units.

## Operation
- States: IDLE (credit = 0), ACCUM (0 < credit < PRICE), VEND, CHANGE, REFUND.
- In IDLE/ACCUM, the sum `s = credit + (a?VAL_A:0) + (b?VAL_B:0)`.
  - Coins `a` and `b` in the same cycle are both credited; neither has priority.
  - `s >= PRICE`: go to VEND, credit ← `s - PRICE`.
  - `0 < s < PRICE`: go to or stay in ACCUM, credit ← s.
  - `s == 0`: stay in IDLE.
- VEND lasts one cycle. Next state is CHANGE if credit ≠ 0, else IDLE.
- CHANGE: each cycle decrements credit by 1. Exit to IDLE on the edge where credit goes 1→0.
- REFUND: same as CHANGE, but is entered from ACCUM by `cancel` (see Configuration).
- Outputs are Moore-decoded from the registered state:
  - `outp` = (state == VEND).
  - `charge` = (state ∈ {CHANGE, REFUND}).
  - `busy` = (state ∈ {VEND, CHANGE, REFUND}).
  - `outp` and `charge` are never high in the same cycle.
- Coins arriving while busy are ignored: not credited, not queued. The upstream acceptor returns them mechanically.
- Credit never exceeds `PRICE-1+VAL_A+VAL_B`. No wrap-around is possible with a legal `CREDIT_W`.

## Timing
- Reset (`rst == 0` at an edge): state IDLE, credit 0, `outp` = `charge` = `busy` = 0 from the next cycle. Reset overrides everything, including mid-VEND/CHANGE/REFUND. Undispensed change is discarded.
- Coin sampled at edge N → credit updated and visible on `credit` after edge N.
- Price reached at edge N → `outp` high during cycle N+1 → first `charge` in cycle N+2.
- Change of k units → `charge` high for exactly k consecutive cycles. `busy` falls together with the last `charge` cycle.
- Minimum coin-to-coin acceptance interval: 1 cycle while not busy.

## Configuration
- `VEND_REFUND_EN` defined:
  - `cancel == 1` in ACCUM → REFUND next edge. A coin in the same cycle is credited first; refund covers the total.
  - `cancel` in IDLE, or while busy, is ignored.
  - If the coin in that cycle completes the price, the vend takes priority and `cancel` is ignored.
- `VEND_REFUND_EN` undefined: `cancel` port is present but ignored. REFUND state is not built; credit is held until a vend.

## Test plan
- PRICE=2, VAL_A=1, VAL_B=2. Pulse `a`, idle 3 cycles, pulse `a` → `credit` 1 then 0, one `outp` cycle, no `charge`.
- Same config. Pulse `a`, then pulse `b` → `outp` 1 cycle, then `charge` 1 cycle, then IDLE with `busy` = 0.
- PRICE=4, VAL_A=1, VAL_B=2. Assert `a` and `b` together, then `b` → credit 3, then vend with 1 change pulse.
- Pulse `b` during VEND and during CHANGE → credit unchanged, no extra `outp`.
- `VEND_REFUND_EN`, PRICE=4. Pulse `b`, then `cancel` → 2 `charge` cycles, no `outp`, credit 0. Without the macro → credit stays 2.
- PRICE=2, VAL_B=5. Pulse `b`, then assert `rst` low during the 2nd `charge` cycle → next cycle all outputs 0, credit 0, IDLE.
